// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: default widths, FSM encoding and the
// saturating load-count helper.
package imem_arbiter_pkg;

    localparam int unsigned DefIsaWidth   = 32;
    localparam int unsigned DefMemAw      = 14;
    localparam int unsigned DefRestartCyc = 2;
    localparam int unsigned CountW        = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StQuiesce = 2'd1,
        StLoad    = 2'd2,
        StRestart = 2'd3
    } ima_state_e;

    function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
        return (v == {CountW{1'b1}}) ? v : v + CountW'(1);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and ROM-side signals around the instruction-ROM arbiter.
// master drives fetch/loader inputs and observes the ROM side; slave is the arbiter.
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned IsaWidth = DefIsaWidth,
    parameter int unsigned MemAw    = DefMemAw
);

    logic [IsaWidth-1:0] fetch_pc;
    logic                load_req;
    logic                ld_valid;
    logic [MemAw-1:0]    ld_addr;
    logic [IsaWidth-1:0] ld_data;
    logic                ld_done;
    logic                ld_ready;
    logic                cpu_hold;
    logic [MemAw-1:0]    mem_addr;
    logic                mem_we;
    logic [IsaWidth-1:0] mem_wdata;
    logic [CountW-1:0]   load_count;

    modport master (
        output fetch_pc, load_req, ld_valid, ld_addr, ld_data, ld_done,
        input  ld_ready, cpu_hold, mem_addr, mem_we, mem_wdata, load_count
    );

    modport slave (
        input  fetch_pc, load_req, ld_valid, ld_addr, ld_data, ld_done,
        output ld_ready, cpu_hold, mem_addr, mem_we, mem_wdata, load_count
    );

endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction ROM between instruction fetch (RUN) and the UART
// program loader (LOAD), holding the CPU in reset while the image is being rewritten.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned IsaWidth   = DefIsaWidth,
    parameter int unsigned MemAw      = DefMemAw,
    parameter int unsigned RestartCyc = DefRestartCyc
) (
    input logic           clock,
    input logic           reset,
    imem_arbiter_if.slave bus
);

    localparam int unsigned    RcW    = (RestartCyc > 1) ? $clog2(RestartCyc) : 1;
    localparam logic [RcW-1:0] RcLast = RcW'(RestartCyc - 1);

    ima_state_e        state_q, state_d;
    logic              load_req_q;
    logic              load_rise;
    logic [RcW-1:0]    rc_q, rc_d;
    logic [CountW-1:0] count_q, count_d;
    logic              xfer;
    logic              unused_pc;

    // Only a fresh switch edge starts a load, so a switch left on after RESTART does not loop.
    assign load_rise = bus.load_req & ~load_req_q;
    assign xfer      = bus.ld_valid & bus.ld_ready;
    assign unused_pc = ^{bus.fetch_pc[IsaWidth-1:MemAw+2], bus.fetch_pc[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            load_req_q <= 1'b0;
            rc_q       <= '0;
            count_q    <= '0;
        end else begin
            load_req_q <= bus.load_req;
            rc_q       <= rc_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (load_rise) state_d = StQuiesce;
            end
            StQuiesce: begin
                state_d = StLoad;
            end
            StLoad: begin
                if (bus.ld_done || !bus.load_req) state_d = StRestart;
            end
            StRestart: begin
                if (rc_q == RcLast) state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Restart counter idles at zero so every RESTART visit lasts exactly RestartCyc cycles.
    always_comb begin
        rc_d    = '0;
        count_d = count_q;
        if (state_q == StRestart) rc_d = rc_q + RcW'(1);
        if (state_q == StQuiesce) begin
            count_d = '0;
        end else if (xfer) begin
            count_d = sat_inc(count_q);
        end
    end

    always_comb begin
        bus.cpu_hold  = 1'b1;
        bus.ld_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            StRun: begin
                bus.cpu_hold = 1'b0;
                bus.mem_addr = bus.fetch_pc[MemAw+1:2];
            end
            StLoad: begin
                // Gating with reset drops a write that coincides with a reset request.
                bus.ld_ready  = reset;
                bus.mem_we    = bus.ld_valid & reset;
                bus.mem_addr  = bus.ld_addr;
                bus.mem_wdata = bus.ld_data;
            end
            default: begin
            end
        endcase
    end

    assign bus.load_count = count_q;

    mem_we_only_in_load: assert property (@(posedge clock) bus.mem_we |-> (state_q == StLoad));

    hold_outside_run: assert property (@(posedge clock) disable iff (!reset)
        (state_q != StRun) |-> bus.cpu_hold);

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: stimulus tasks push per-cycle and per-write
// expectations, a negedge monitor pops and compares them against the ROM/loader outputs.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int unsigned RC = 2;

    typedef struct {
        bit          chk_hold;
        bit          hold;
        bit          chk_ready;
        bit          ready;
        bit          we;
        bit          chk_addr;
        logic [13:0] addr;
        bit          chk_wdata;
        logic [31:0] wdata;
        bit          chk_count;
        logic [15:0] count;
        string       tag;
    } exp_t;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    imem_arbiter_if bus ();

    imem_arbiter #(.RestartCyc(RC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] cnt   = 16'd0;

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s [%s]: got %0h, want %0h", name, tag, act, want);
        end
    endtask

    function automatic exp_t mk(input bit hold, input bit ready, input bit we, input bit chk_addr,
                                input logic [13:0] addr, input bit chk_wdata,
                                input logic [31:0] wdata, input string tag);
        exp_t e;
        e.chk_hold  = 1'b1;
        e.hold      = hold;
        e.chk_ready = 1'b1;
        e.ready     = ready;
        e.we        = we;
        e.chk_addr  = chk_addr;
        e.addr      = addr;
        e.chk_wdata = chk_wdata;
        e.wdata     = wdata;
        e.chk_count = 1'b1;
        e.count     = cnt;
        e.tag       = tag;
        return e;
    endfunction

    // Monitor: per-cycle status plus every ROM write the DUT presents.
    exp_t me;
    wr_t  mw;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            if (me.chk_hold) chk("cpu_hold", me.tag, 32'(bus.cpu_hold), 32'(me.hold));
            if (me.chk_ready) chk("ld_ready", me.tag, 32'(bus.ld_ready), 32'(me.ready));
            chk("mem_we", me.tag, 32'(bus.mem_we), 32'(me.we));
            if (me.chk_addr) chk("mem_addr", me.tag, 32'(bus.mem_addr), 32'(me.addr));
            if (me.chk_wdata) chk("mem_wdata", me.tag, bus.mem_wdata, me.wdata);
            if (me.chk_count) chk("load_count", me.tag, 32'(bus.load_count), 32'(me.count));
        end
        if (bus.mem_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, want no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                mw = wr_q.pop_front();
                chk("wr_addr", "write", 32'(bus.mem_addr), 32'(mw.addr));
                chk("wr_data", "write", bus.mem_wdata, mw.data);
            end
        end
    end

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic junk_loader();
        bus.ld_valid = 1'($urandom_range(0, 1));
        bus.ld_done  = 1'($urandom_range(0, 1));
        bus.ld_addr  = 14'($urandom());
        bus.ld_data  = $urandom();
    endtask

    // RUN cycles: ROM address is the fetch word address, loader traffic ignored.
    task automatic run_cyc(input int n, input bit lr, input string tag);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = $urandom();
            bus.fetch_pc = pc;
            bus.load_req = lr;
            junk_loader();
            step(mk(1'b0, 1'b0, 1'b0, 1'b1, 14'(pc / 4), 1'b0, 32'd0, tag));
        end
    endtask

    // Raise load_req in RUN, then the single QUIESCE cycle; count clears afterwards.
    task automatic start_load(input string tag);
        logic [31:0] pc;
        pc = $urandom();
        bus.fetch_pc = pc;
        bus.load_req = 1'b1;
        junk_loader();
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 14'(pc / 4), 1'b0, 32'd0, {tag, "_run"}));
        bus.fetch_pc = $urandom();
        junk_loader();
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'd0, {tag, "_quiesce"}));
        cnt = 16'd0;
    endtask

    task automatic load_cyc(input bit v, input bit done, input bit lr, input logic [13:0] a,
                            input logic [31:0] d, input string tag);
        wr_t w;
        bus.fetch_pc = $urandom();
        bus.load_req = lr;
        bus.ld_valid = v;
        bus.ld_done  = done;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        if (v) begin
            w.addr = a;
            w.data = d;
            wr_q.push_back(w);
        end
        step(mk(1'b1, 1'b1, v, 1'b1, a, 1'b1, d, tag));
        if (v && cnt != 16'hFFFF) cnt = cnt + 16'd1;
    endtask

    task automatic restart_cycles(input bit lr, input string tag);
        for (int i = 0; i < int'(RC); i++) begin
            bus.fetch_pc = $urandom();
            bus.load_req = lr;
            junk_loader();
            step(mk(1'b1, 1'b0, 1'b0, 1'b1, 14'd0, 1'b0, 32'd0, tag));
        end
    endtask

    initial begin
        bit ends_done;
        bit hold_sw;
        bus.fetch_pc = '0;
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_done  = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // 1: reset state and RUN address mapping
        bus.fetch_pc = 32'h0000_0010;
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 14'd4, 1'b1, 32'd0, "t1_reset"));
        run_cyc(2, 1'b0, "t1_run");

        // 2: three-word load ending on ld_done, switch left on through RESTART
        start_load("t2");
        for (int i = 0; i < 3; i++) begin
            load_cyc(1'b1, 1'b0, 1'b1, 14'(i), 32'h2408_0001 + 32'(i), "t2_word");
        end
        load_cyc(1'b0, 1'b1, 1'b1, 14'h1234, 32'h0, "t2_done");
        restart_cycles(1'b1, "t2_restart");
        run_cyc(2, 1'b1, "t2_no_reload");
        run_cyc(1, 1'b0, "t2_run");

        // 3: word and ld_done in the same cycle
        start_load("t3");
        load_cyc(1'b1, 1'b1, 1'b1, 14'd5, 32'hDEAD_BEEF, "t3_word_done");
        restart_cycles(1'b0, "t3_restart");
        run_cyc(1, 1'b0, "t3_run");

        // 4: abort after two words keeps the count
        start_load("t4");
        load_cyc(1'b1, 1'b0, 1'b1, 14'($urandom()), $urandom(), "t4_word");
        load_cyc(1'b1, 1'b0, 1'b1, 14'($urandom()), $urandom(), "t4_word");
        load_cyc(1'b0, 1'b0, 1'b0, 14'($urandom()), $urandom(), "t4_abort");
        restart_cycles(1'b0, "t4_restart");

        // 5: loader word while running is ignored
        bus.fetch_pc = 32'h0000_0100;
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_done  = 1'b0;
        bus.ld_addr  = 14'd0;
        bus.ld_data  = 32'hFFFF_FFFF;
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 14'h40, 1'b0, 32'd0, "t5_run_valid"));

        // 6: reset during LOAD with a word pending
        start_load("t6");
        load_cyc(1'b1, 1'b0, 1'b1, 14'd7, 32'h1111_2222, "t6_word");
        reset = 1'b0;
        bus.load_req = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_done  = 1'b0;
        bus.ld_addr  = 14'd9;
        bus.ld_data  = 32'h3333_4444;
        begin
            exp_t e;
            e = mk(1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'd0, "t6_reset_cycle");
            e.chk_hold  = 1'b0;
            e.chk_ready = 1'b0;
            e.chk_count = 1'b0;
            step(e);
        end
        reset = 1'b1;
        cnt = 16'd0;
        run_cyc(2, 1'b0, "t6_after_reset");

        // Randomized loads
        for (int k = 0; k < 12; k++) begin
            run_cyc(int'($urandom_range(1, 3)), 1'b0, "r_run");
            start_load("r");
            for (int j = 0; j < int'($urandom_range(0, 6)); j++) begin
                load_cyc(1'($urandom_range(0, 3) != 0), 1'b0, 1'b1, 14'($urandom()),
                         $urandom(), "r_word");
            end
            ends_done = 1'($urandom_range(0, 1));
            hold_sw   = ends_done & 1'($urandom_range(0, 1));
            load_cyc(1'($urandom_range(0, 1)), ends_done, ends_done, 14'($urandom()),
                     $urandom(), "r_last");
            restart_cycles(hold_sw, "r_restart");
            if (hold_sw) run_cyc(int'($urandom_range(1, 2)), 1'b1, "r_no_reload");
        end
        run_cyc(2, 1'b0, "final_run");

        @(posedge clock);
        #1;
        chk("exp_q_left", "end", 32'(exp_q.size()), 32'd0);
        chk("wr_q_left", "end", 32'(wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
